pw_core_param: RTL
==================

# pw_core_param

Parametrised successor of the 8-bit Picowizard core: same register file (A, B, C, SEG), opcode map and carry semantics, generalised to a DW-bit datapath with a 2·DW-bit address space. It adds a memory wait-state handshake (MemReady), an explicit FSM in place of the free-running 2-bit microcounter, and a sticky Halted status. It drives a single shared program/data memory port, exactly as the 8-bit core does.

## Interface
- DW, 8: data width; must be ≥ 8. The address width is 2·DW.
- RESET_PC, 0: PC value loaded on reset (2·DW bits).
- Clk  in  1  sole clock; all state updates on the rising edge.
- CPUEn  in  1  synchronous, active-low reset: CPUEn=0 at a rising edge resets the core; CPUEn=1 runs it.
- DataIn  in  DW  memory read data; the opcode is DataIn[7:0].
- MemReady  in  1  memory has completed the current LdMem/WrtMem access in this cycle.
- LdMem  out  1  read request.
- WrtMem  out  1  write request.
- DataOut  out  DW  write data (register rd).
- AdrOut  out  2·DW  memory address.
- Halted  out  1  core stopped on PC wrap.

## Operation
- Registers: A=00, B=01, C=10, SEG=11. Fields: rd=op[4:3], rs=op[1:0]. Carry is 1 bit.
- On reset: A, B, C, SEG=0; Carry=0; PC=RESET_PC; state=FETCH. Outputs while CPUEn=0: LdMem=0, WrtMem=0, Halted=0, AdrOut=RESET_PC, DataOut=0.
- Opcode map:
  - op[7:6]=00 MOV: rd←rs.
  - op[7:6]=01 ALU: {op[5],op[2]} selects the operation.
    - 00 ADD: rd←rd+rs.
    - 01 ADC: rd←rd+rs+Carry.
    - 10 NAND: rd←~(rd&rs).
    - 11 XOR: rd←rd^rs.
    - Carry←carry-out of bit DW-1 for ADD/ADC; Carry←1 for NAND/XOR.
  - op[7:6]=10, op[5]=0, op[2]=0 LD: rd←M[{SEG,rs}].
  - op[7:6]=10, op[5]=0, op[2]=1 ST: M[{SEG,rs}]←rd.
  - op[7:6]=10, op[5]=1, op[2]=0 BZ: if rd==0 then PC←{SEG,rs}.
  - op[7:6]=10, op[5]=1, op[2]=1 CALL: PC←{rd,rs}; {C,B}←PC_ret.
    - PC_ret is the address after the opcode.
    - The jump target is formed from register values read before the {C,B} write.
  - op[7:6]=11 LDI: rd←M[PC_ret]; PC advances by 2 in total.
  - Opcode bits DW-1:8 are ignored. Unused bits (e.g. op[5], op[2] in MOV) are don't-care.
- States:
  - FETCH:
    - Drives AdrOut=PC, LdMem=1.
    - On MemReady: latch opcode, compute PC+1, go to EXEC.
    - If PC+1 carries out of 2·DW bits, go to HALT instead (PC unchanged).
  - EXEC, for MOV/ALU/BZ/CALL:
    - No memory access.
    - Writes register/Carry/PC at the end of this single cycle, then goes to FETCH.
  - EXEC, for LD/ST/LDI:
    - Holds the access until MemReady, performs the write-back in that cycle, then goes to FETCH.
    - LD: AdrOut={SEG,rs}, LdMem=1.
    - ST: AdrOut={SEG,rs}, WrtMem=1, DataOut=rd.
    - LDI: AdrOut=PC, LdMem=1, and PC←PC+1 on completion.
    - If the LDI increment wraps, the load still completes, then the core goes to HALT.
  - HALT: LdMem=WrtMem=0, Halted=1, AdrOut=PC. Exits only via CPUEn=0.
- LdMem and WrtMem are never both 1. DataOut=rd whenever WrtMem=1, and 0 otherwise.

## Timing
- Request outputs are Moore/decoded from the registered state and opcode. Requests stay asserted, with AdrOut and DataOut stable, until the cycle MemReady=1 is sampled.
- Zero-wait latency (MemReady tied 1):
  - MOV/ALU/BZ/CALL: 2 cycles.
  - LD/ST/LDI: 2 cycles.
  - Each wait cycle adds 1 cycle.
- MemReady while no request is outstanding is ignored.
- Register results are visible to the next instruction's EXEC; there is no forwarding hazard because execution is sequential.
- CPUEn=0 mid-access drops LdMem/WrtMem in the following cycle. The reset takes priority over any write-back in the same edge.
- A taken BZ/CALL updates the PC at the end of EXEC; the next FETCH uses the target.

## Test plan
- Reset/fetch:
  - Stimulus: CPUEn 0→1, RESET_PC=0, MemReady=1, memory 0x00: C7 05 (LDI A,5).
  - Response: AdrOut 0x0000 then 0x0001; A=0x05 after 2 cycles; next fetch at 0x0002.
- ALU/carry, DW=8:
  - Stimulus: A=0xFF, B=0x01; ADD A,B (0x41); then ADC B,A (0x4C).
  - Response: A=0x00, Carry=1; B=0x02, Carry=0.
  - Stimulus: NAND A,A (0x60).
  - Response: A=0xFF, Carry=1.
- Wait states:
  - Stimulus: MemReady low for 3 cycles during ST A→{SEG,B} with SEG=0x12, B=0x34, A=0xAA.
  - Response: WrtMem=1, AdrOut=0x1234, DataOut=0xAA held for 4 cycles, then a single write.
- Branch/call:
  - BZ A with A=0, SEG=0x03, rs=B=0x10: next fetch at 0x0310.
  - BZ A with A=1: falls through to PC+1.
  - CALL at 0x0020 with A=0x40, B=0x00: jump to 0x4000; C=0x00, B=0x21.
- Wrap/halt, DW=8:
  - Stimulus: RESET_PC=0xFFFF, opcode MOV at 0xFFFF.
  - Response: Halted=1 after FETCH completes; LdMem=0 thereafter; CPUEn pulse low clears Halted.
- Width generality, DW=16:
  - Stimulus: ADD with 0xFFFF+0x0001; LD at {SEG,rs}=0x0001_0002.
  - Response: result 0x0000, Carry=1; AdrOut is 32 bits and correct.

Source files
------------

// File: rtl/pw_core_param_if.sv
// Shared program/data memory port of the pw_core_param core.
// The core is the master; the memory (or bench model) is the slave.
interface pw_core_param_if #(
    parameter int DW = 8
);
    logic [DW-1:0]   DataIn;
    logic            MemReady;
    logic            LdMem;
    logic            WrtMem;
    logic [DW-1:0]   DataOut;
    logic [2*DW-1:0] AdrOut;

    modport master (
        input  DataIn, MemReady,
        output LdMem, WrtMem, DataOut, AdrOut
    );

    modport slave (
        output DataIn, MemReady,
        input  LdMem, WrtMem, DataOut, AdrOut
    );
endinterface

// File: rtl/pw_core_param.sv
// Parametrised Picowizard core: DW-bit datapath, 2*DW-bit address space,
// FETCH/EXEC/HALT sequencer with memory wait states and a sticky Halted flag.
module pw_core_param #(
    parameter int              DW       = 8,
    parameter logic [2*DW-1:0] RESET_PC = '0
) (
    input  logic            Clk,
    input  logic            CPUEn,
    pw_core_param_if.master Mem,
    output logic            Halted
);
    localparam int AW = 2 * DW;

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
    typedef enum logic [2:0] {OP_MOV, OP_ALU, OP_LD, OP_ST, OP_BZ, OP_CALL, OP_LDI} opClass_t;

    state_t        state;
    logic [7:0]    opcode;
    logic [AW-1:0] pc;
    logic [DW-1:0] regs [4];
    logic          carry;

    function automatic opClass_t decode(input logic [7:0] op);
        opClass_t cls;
        case (op[7:6])
            2'b00: cls = OP_MOV;
            2'b01: cls = OP_ALU;
            2'b10: begin
                case ({op[5], op[2]})
                    2'b00:   cls = OP_LD;
                    2'b01:   cls = OP_ST;
                    2'b10:   cls = OP_BZ;
                    default: cls = OP_CALL;
                endcase
            end
            default: cls = OP_LDI;
        endcase
        return cls;
    endfunction

    function automatic logic isMemOp(input opClass_t cls);
        return (cls == OP_LD) || (cls == OP_ST) || (cls == OP_LDI);
    endfunction

    // Result in [DW-1:0], carry in [DW]; logic ops always set carry.
    function automatic logic [DW:0] aluOp(input logic [1:0] sel, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic cin);
        logic [DW:0] r;
        case (sel)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
            2'b10:   r = {1'b1, ~(a & b)};
            default: r = {1'b1, a ^ b};
        endcase
        return r;
    endfunction

    logic [7:0]    fetchOp;
    opClass_t      newClass;
    opClass_t      curClass;
    logic [DW-1:0] rdVal;
    logic [DW-1:0] rsVal;
    logic [AW:0]   pcInc;
    logic [DW:0]   aluOut;
    logic [AW-1:0] execNextPc;

    assign fetchOp  = Mem.DataIn[7:0];
    assign newClass = decode(fetchOp);
    assign curClass = decode(opcode);
    assign rdVal    = regs[opcode[4:3]];
    assign rsVal    = regs[opcode[1:0]];
    assign pcInc    = {1'b0, pc} + {{AW{1'b0}}, 1'b1};
    assign aluOut   = aluOp({opcode[5], opcode[2]}, rdVal, rsVal, carry);

    // pc already holds the return address while in EXEC.
    always_comb begin
        execNextPc = pc;
        case (curClass)
            OP_BZ:   execNextPc = (rdVal == '0) ? {regs[3], rsVal} : pc;
            OP_CALL: execNextPc = {rdVal, rsVal};
            OP_LDI:  execNextPc = pcInc[AW-1:0];
            default: execNextPc = pc;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!CPUEn) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            carry       <= 1'b0;
            opcode      <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            Mem.LdMem   <= 1'b0;
            Mem.WrtMem  <= 1'b0;
            Mem.DataOut <= '0;
            Mem.AdrOut  <= RESET_PC;
            Halted      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    // First cycle out of reset only raises the read request.
                    if (!Mem.LdMem) begin
                        Mem.LdMem <= 1'b1;
                    end else if (Mem.MemReady) begin
                        if (pcInc[AW]) begin
                            state     <= HALT;
                            Mem.LdMem <= 1'b0;
                            Halted    <= 1'b1;
                        end else begin
                            state       <= EXEC;
                            opcode      <= fetchOp;
                            pc          <= pcInc[AW-1:0];
                            Mem.LdMem   <= (newClass == OP_LD) || (newClass == OP_LDI);
                            Mem.WrtMem  <= (newClass == OP_ST);
                            Mem.DataOut <= (newClass == OP_ST) ? regs[fetchOp[4:3]] : '0;
                            Mem.AdrOut  <= (newClass == OP_LD || newClass == OP_ST)
                                           ? {regs[3], regs[fetchOp[1:0]]} : pcInc[AW-1:0];
                        end
                    end
                end
                EXEC: begin
                    if (!isMemOp(curClass) || Mem.MemReady) begin
                        case (curClass)
                            OP_MOV: regs[opcode[4:3]] <= rsVal;
                            OP_ALU: begin
                                regs[opcode[4:3]] <= aluOut[DW-1:0];
                                carry             <= aluOut[DW];
                            end
                            OP_LD, OP_LDI: regs[opcode[4:3]] <= Mem.DataIn;
                            OP_CALL: begin
                                regs[2] <= pc[AW-1:DW];
                                regs[1] <= pc[DW-1:0];
                            end
                            default: ;
                        endcase
                        Mem.WrtMem  <= 1'b0;
                        Mem.DataOut <= '0;
                        if (curClass == OP_LDI && pcInc[AW]) begin
                            state      <= HALT;
                            Mem.LdMem  <= 1'b0;
                            Mem.AdrOut <= pc;
                            Halted     <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            pc         <= execNextPc;
                            Mem.LdMem  <= 1'b1;
                            Mem.AdrOut <= execNextPc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
